// File: rtl/mdu_seq.sv
// mdu_seq: multiply/divide sequencer owning the architectural HI/LO registers.
// Handles MULT/MULTU (one extra cycle), DIV/DIVU (32-iteration restoring
// divider plus a sign-fix cycle) and MTHI/MTLO (immediate write).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   MDU_Start  request strobe, sampled only while idle
//   MDU_Op     001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   MDU_A      rs operand (dividend / multiplicand / MTHI-MTLO data)
//   MDU_B      rt operand (divisor / multiplier)
//   MDU_Flush  abort any in-flight operation, cancels a same-cycle request
//   MDU_Busy   registered, high while an operation is in flight
//   MDU_Done   one-cycle pulse after HI/LO write-back of MULT/DIV
//   MDU_HI     HI register
//   MDU_LO     LO register
module mdu_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MDU_Start,
  input  logic [2:0]        MDU_Op,
  input  logic [DATA_W-1:0] MDU_A,
  input  logic [DATA_W-1:0] MDU_B,
  input  logic              MDU_Flush,
  output logic              MDU_Busy,
  output logic              MDU_Done,
  output logic [DATA_W-1:0] MDU_HI,
  output logic [DATA_W-1:0] MDU_LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which reads correctly as the unsigned magnitude 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + ONE) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + ONE) : v;
  endfunction

  state_t            state;
  logic [5:0]        cnt;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Operand / divider datapath registers. quo_p0 holds the multiplicand
  // for MUL and the dividend-shifting-into-quotient for DIV.
  logic [DATA_W-1:0] quo_p0;
  logic [DATA_W-1:0] div_p0;
  logic [DATA_W:0]   rem_p0;
  logic              mul_sgn_p0;
  logic              q_neg_p0;
  logic              r_neg_p0;
  logic              no_wr_p0;

  logic              op_valid;
  logic              accept;
  logic              div_sgn;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_trial;
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] mul_b;
  logic [2*DATA_W-1:0] product;

  assign op_valid = (MDU_Op != 3'b000) && (MDU_Op != 3'b111);
  assign accept   = (state == S_IDLE) && MDU_Start && !MDU_Flush && op_valid;
  assign div_sgn  = (MDU_Op == OP_DIV);

  // One restoring-division step: shift in the next dividend bit, trial-subtract.
  assign rem_shift = {rem_p0[DATA_W-1:0], quo_p0[DATA_W-1]};
  assign rem_trial = rem_shift - {1'b0, div_p0};

  // Sign-extending to 2*DATA_W makes the low half of an unsigned multiply
  // equal to the signed product, so one multiplier serves MULT and MULTU.
  assign mul_a   = {{DATA_W{mul_sgn_p0 & quo_p0[DATA_W-1]}}, quo_p0};
  assign mul_b   = {{DATA_W{mul_sgn_p0 & div_p0[DATA_W-1]}}, div_p0};
  assign product = mul_a * mul_b;

  // ---- stage p0: operand capture and divider iteration ----
  always_ff @(posedge clk) begin
    if (accept) begin
      case (MDU_Op)
        OP_MULT, OP_MULTU: begin
          quo_p0     <= MDU_A;
          div_p0     <= MDU_B;
          mul_sgn_p0 <= (MDU_Op == OP_MULT);
        end
        OP_DIV, OP_DIVU: begin
          quo_p0   <= div_sgn ? abs_val(MDU_A) : MDU_A;
          div_p0   <= div_sgn ? abs_val(MDU_B) : MDU_B;
          rem_p0   <= '0;
          q_neg_p0 <= div_sgn & (MDU_A[DATA_W-1] ^ MDU_B[DATA_W-1]);
          r_neg_p0 <= div_sgn & MDU_A[DATA_W-1];
          no_wr_p0 <= (MDU_B == '0);
        end
        default: ;
      endcase
    end else if (state == S_DIV) begin
      if (!rem_trial[DATA_W]) begin
        rem_p0 <= rem_trial;
        quo_p0 <= {quo_p0[DATA_W-2:0], 1'b1};
      end else begin
        rem_p0 <= rem_shift;
        quo_p0 <= {quo_p0[DATA_W-2:0], 1'b0};
      end
    end
  end

  // ---- control FSM and architectural HI/LO ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (MDU_Flush && (state != S_IDLE)) begin
        state <= S_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              case (MDU_Op)
                OP_MULT, OP_MULTU: begin
                  state <= S_MUL;
                  busy  <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                  // Zero divisor skips the loop; FIX then leaves HI/LO alone.
                  state <= (MDU_B == '0) ? S_FIX : S_DIV;
                  cnt   <= '0;
                  busy  <= 1'b1;
                end
                OP_MTHI: hi <= MDU_A;
                OP_MTLO: lo <= MDU_A;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            hi    <= product[2*DATA_W-1:DATA_W];
            lo    <= product[DATA_W-1:0];
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          S_DIV: begin
            if (cnt == 6'd31) begin
              state <= S_FIX;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          S_FIX: begin
            if (!no_wr_p0) begin
              lo <= cond_neg(quo_p0, q_neg_p0);
              hi <= cond_neg(rem_p0[DATA_W-1:0], r_neg_p0);
            end
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign MDU_Busy = busy;
  assign MDU_Done = done;
  assign MDU_HI   = hi;
  assign MDU_LO   = lo;

endmodule
